// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage. Issues one instruction-bus request at a
//            time, presents the fetched word with its PC to IF/ID, handles
//            redirects (discarding in-flight data) and flags misaligned PCs.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] target_i,
    output logic        ireq_o,
    output logic [31:0] iaddr_o,
    input  logic        iack_i,
    input  logic [31:0] idata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_add4_o,
    output logic [31:0] inst_o,
    output logic        exc_addr_o,
    output logic        ready_o
);

    localparam logic [31:0] c_nop = 32'h0000_0033;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DROP  = 3'd1,
        S_VALID = 3'd2,
        S_EXC   = 3'd3,
        S_PARK  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] r_req_addr;
    logic        r_armed;
    logic        w_inst_ld;
    logic        w_req_hold;
    logic        w_aligned;
    logic        w_req_active;
    logic [31:0] w_pc_add4;

    // A misaligned address never reaches the bus: it goes straight to EXC.
    function automatic state_t f_enter(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) ? S_EXC : S_FETCH;
    endfunction

    assign w_aligned    = (r_pc[1:0] == 2'b00);
    assign w_pc_add4    = r_pc + 32'd4;
    // r_armed keeps the request low until the first edge after reset release.
    assign w_req_active = r_armed &&
                          (((r_state == S_FETCH) && w_aligned) || (r_state == S_DROP));

    // Next-state and PC selection; a redirect outranks stall and acknowledge.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_ld   = 1'b0;
        w_req_hold  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (jump_i) begin
                    w_pc_nxt = target_i;
                    if (w_req_active && !iack_i) begin
                        // Request still in flight: keep it on the bus, drop its data.
                        w_state_nxt = S_DROP;
                        w_req_hold  = 1'b1;
                    end else begin
                        w_state_nxt = f_enter(target_i);
                    end
                end else if (!r_armed) begin
                    w_state_nxt = S_FETCH;
                end else if (!w_aligned) begin
                    w_state_nxt = S_EXC;
                end else if (iack_i) begin
                    w_inst_ld   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_DROP: begin
                if (jump_i) begin
                    w_pc_nxt = target_i;
                end
                if (iack_i) begin
                    w_state_nxt = f_enter(jump_i ? target_i : r_pc);
                end
            end
            S_VALID: begin
                if (jump_i) begin
                    w_pc_nxt    = target_i;
                    w_state_nxt = f_enter(target_i);
                end else if (!stall_i) begin
                    w_pc_nxt    = w_pc_add4;
                    w_state_nxt = f_enter(w_pc_add4);
                end
            end
            S_EXC: begin
                if (jump_i) begin
                    w_pc_nxt    = target_i;
                    w_state_nxt = f_enter(target_i);
                end else if (!stall_i) begin
                    w_state_nxt = S_PARK;
                end
            end
            S_PARK: begin
                if (jump_i) begin
                    w_pc_nxt    = target_i;
                    w_state_nxt = f_enter(target_i);
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State, PC, instruction and held bus address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_ADDR;
            r_inst     <= c_nop;
            r_req_addr <= RESET_ADDR;
            r_armed    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_armed <= 1'b1;
            if (w_inst_ld) begin
                r_inst <= idata_i;
            end
            if (w_req_hold) begin
                r_req_addr <= r_pc;
            end
        end
    end

    assign ireq_o     = w_req_active;
    assign iaddr_o    = (r_state == S_DROP) ? r_req_addr : r_pc;
    assign ready_o    = (r_state == S_VALID) || (r_state == S_EXC);
    assign exc_addr_o = (r_state == S_EXC);
    assign inst_o     = (r_state == S_VALID) ? r_inst : c_nop;
    assign pc_o       = r_pc;
    assign pc_add4_o  = w_pc_add4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Scoreboard bench for if_stage with a randomized bus responder and
//            a transaction-level model of which PC is presented next.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0033;
    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] target_i;
    logic        ireq_o;
    logic [31:0] iaddr_o;
    logic        iack_i;
    logic [31:0] idata_i;
    logic [31:0] pc_o;
    logic [31:0] pc_add4_o;
    logic [31:0] inst_o;
    logic        exc_addr_o;
    logic        ready_o;

    if_stage #(.RESET_ADDR(RST_A)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i), .target_i(target_i),
        .ireq_o(ireq_o), .iaddr_o(iaddr_o), .iack_i(iack_i), .idata_i(idata_i),
        .pc_o(pc_o), .pc_add4_o(pc_add4_o), .inst_o(inst_o),
        .exc_addr_o(exc_addr_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          lat_mode = 2;
    int          wd_cnt = 0;
    logic [31:0] last_pc = RST_A;
    logic        last_exc = 1'b0;

    // Memory contents seen by the bus; address 0 holds the reference word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        chk(nm, {31'd0, act}, {31'd0, req});
    endtask

    // The next presentation is always the most recent redirect target, or the
    // sequential successor once the current instruction is consumed.
    function automatic void push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.exc  = (pc[1:0] != 2'b00);
        e.inst = e.exc ? NOP : mem(pc);
        sb_q.delete();
        sb_q.push_back(e);
        last_pc  = pc;
        last_exc = e.exc;
        wd_cnt   = 0;
    endfunction

    task automatic apply(input logic st, input logic jp, input logic [31:0] tg);
        stall_i  = st;
        jump_i   = jp;
        target_i = jp ? tg : $urandom;
        if (jp) push_exp(tg);
        else if (ready_o && !st && !last_exc) push_exp(last_pc + 32'd4);
        if (sb_q.size() != 0) begin
            wd_cnt++;
            if (wd_cnt > 40) begin
                total++;
                bad++;
                $display("FAIL watchdog: actual=no presentation required=pc %h", sb_q[0].pc);
                sb_q.delete();
                wd_cnt = 0;
            end
        end else begin
            wd_cnt = 0;
        end
    endtask

    task automatic tick(input logic st, input logic jp, input logic [31:0] tg);
        @(negedge clk);
        apply(st, jp, tg);
    endtask

    task automatic wait_ready(input string nm);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ready_o) found = 1'b1;
            else apply(1'b0, 1'b0, 32'd0);
        end
        chk1(nm, found, 1'b1);
    endtask

    task automatic wait_ireq(input string nm);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ireq_o) found = 1'b1;
            else apply(1'b0, 1'b0, 32'd0);
        end
        chk1(nm, found, 1'b1);
    endtask

    // Asserts reset mid-cycle, checks the immediate values, releases on a negedge.
    task automatic do_reset();
        stall_i = 1'b0;
        jump_i  = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk1("rst_ireq", ireq_o, 1'b0);
        chk1("rst_ready", ready_o, 1'b0);
        chk1("rst_exc", exc_addr_o, 1'b0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc", pc_o, RST_A);
        chk("rst_pc4", pc_add4_o, RST_A + 32'd4);
        push_exp(RST_A);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk1("rel_ireq", ireq_o, 1'b0);
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned r;
        logic [31:0] t;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        end else if (r == 6) begin
            t = 32'($urandom_range(0, 1023));
            t[1:0] = 2'($urandom_range(1, 3));
        end else if (r == 7) begin
            t = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
        end else begin
            t = $urandom;
        end
        return t;
    endfunction

    // Bus responder: random or fixed latency, checks address stability.
    initial begin : g_bus
        logic        busy = 1'b0;
        logic [31:0] raddr = 32'd0;
        int          wait_n = 0;
        iack_i  = 1'b0;
        idata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                iack_i  = 1'b0;
                busy    = 1'b0;
                idata_i = $urandom;
            end else begin
                if (iack_i) begin
                    iack_i = 1'b0;
                    busy   = 1'b0;
                end
                idata_i = $urandom;
                if (ireq_o) begin
                    if (!busy) begin
                        busy   = 1'b1;
                        raddr  = iaddr_o;
                        wait_n = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    end else begin
                        chk("iaddr_stable", iaddr_o, raddr);
                    end
                    if (wait_n == 0) begin
                        iack_i  = 1'b1;
                        idata_i = mem(iaddr_o);
                    end else begin
                        wait_n--;
                    end
                end else if (busy) begin
                    total++;
                    bad++;
                    $display("FAIL req_dropped: actual=ireq 0 required=ireq 1 addr %h", raddr);
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation on each new presentation, checks holds.
    initial begin : g_mon
        logic prev_ready = 1'b0;
        logic ended;
        exp_t cur;
        cur.pc = 32'd0; cur.inst = NOP; cur.exc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ended = prev_ready && (!stall_i || jump_i);
            if (ready_o) begin
                chk1("ready_no_req", ireq_o, 1'b0);
                if (!prev_ready || ended) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected: actual=pc %h required=no presentation", pc_o);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("pres_pc", pc_o, cur.pc);
                        chk("pres_inst", inst_o, cur.inst);
                        chk1("pres_exc", exc_addr_o, cur.exc);
                        chk("pres_pc4", pc_add4_o, cur.pc + 32'd4);
                    end
                end else begin
                    chk("hold_pc", pc_o, cur.pc);
                    chk("hold_inst", inst_o, cur.inst);
                    chk1("hold_exc", exc_addr_o, cur.exc);
                end
            end else begin
                chk("idle_inst", inst_o, NOP);
                chk1("idle_exc", exc_addr_o, 1'b0);
            end
            prev_ready = ready_o;
        end
    end

    initial begin : g_stim
        logic prev_jp = 1'b0;
        logic jp;
        rst      = 1'b0;
        stall_i  = 1'b0;
        jump_i   = 1'b0;
        target_i = 32'd0;
        lat_mode = 2;
        @(negedge clk);
        do_reset();

        // First fetch, then a 3-cycle stall on the second instruction.
        wait_ready("wait_p0");
        apply(1'b0, 1'b0, 32'd0);
        wait_ready("wait_p4");
        apply(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 32'd0);

        // Redirect while the fetch of 8 is pending.
        wait_ireq("wait_req8");
        chk("req_addr_8", iaddr_o, 32'h8);
        apply(1'b0, 1'b1, 32'h100);

        // Misaligned redirect, exception presentation, then park.
        wait_ready("wait_p100");
        apply(1'b0, 1'b1, 32'h102);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 32'd0);
        repeat (3) begin
            tick(1'b0, 1'b0, 32'd0);
            chk1("park_ireq", ireq_o, 1'b0);
            chk1("park_ready", ready_o, 1'b0);
        end
        tick(1'b0, 1'b1, 32'h200);

        // PC wrap at the top of the address space.
        wait_ready("wait_p200");
        apply(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_ready("wait_pwrap");
        apply(1'b0, 1'b0, 32'd0);
        wait_ireq("wait_req0");
        chk("wrap_addr", iaddr_o, 32'h0);
        apply(1'b0, 1'b0, 32'd0);

        // Reset while that request is outstanding.
        do_reset();

        // Randomized traffic.
        lat_mode = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                prev_jp = 1'b0;
            end else begin
                jp = !prev_jp && ($urandom_range(0, 99) < 7);
                apply(($urandom_range(0, 99) < 35), jp, rand_target());
                prev_jp = jp;
            end
        end
        repeat (20) tick(1'b0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 Parameter: RESET_ADDR, 32'h0000_0000, fetch PC loaded at reset.
- REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
- REQ-003 Port: rst  input  1  reset, asynchronous, active-low; no other clock or reset exists.
- REQ-004 Port: stall_i  input  1  downstream IF/ID holding; current fetch result must be kept.
- REQ-005 Port: jump_i  input  1  redirect request, single-cycle pulse.
- REQ-006 Port: target_i  input  32  redirect address, valid when jump_i=1.
- REQ-007 Port: ireq_o  output  1  instruction bus request.
- REQ-008 Port: iaddr_o  output  32  instruction bus address.
- REQ-009 Port: iack_i  input  1  bus acknowledge; idata_i valid this cycle.
- REQ-010 Port: idata_i  input  32  fetched instruction word.
- REQ-011 Port: pc_o  output  32  PC of presented instruction.
- REQ-012 Port: pc_add4_o  output  32  pc_o+4, modulo 2^32.
- REQ-013 Port: inst_o  output  32  presented instruction.
- REQ-014 Port: exc_addr_o  output  1  misaligned fetch address flag.
- REQ-015 Port: ready_o  output  1  pc_o/inst_o/exc_addr_o valid for IF/ID capture.

Function
- REQ-016 Block SHALL implement a five-state FSM: FETCH, DROP, VALID, EXC, PARK; one bus request outstanding at most.
- REQ-017 FETCH: ireq_o=1, iaddr_o=pc; iaddr_o SHALL stay constant while ireq_o=1 until the iack_i cycle.
- REQ-018 FETCH with iack_i, no jump_i: inst latched from idata_i, next state VALID (ready_o high the cycle after ack).
- REQ-019 VALID: ready_o=1, ireq_o=0, outputs stable; if stall_i=1 remain VALID; if stall_i=0 pc<=pc+4, next state FETCH.
- REQ-020 jump_i SHALL take priority over stall_i and iack_i in every state; pc<=target_i.
- REQ-021 jump_i in FETCH without iack_i: next state DROP; DROP holds ireq_o=1 and the old address; the acknowledged data SHALL be discarded; on iack_i next state FETCH at new pc.
- REQ-022 jump_i in FETCH coincident with iack_i: data discarded, next state FETCH at target_i.
- REQ-023 jump_i in DROP: pc<=newest target_i, remain DROP (last redirect wins).
- REQ-024 jump_i in VALID, EXC or PARK: ready_o=0 next cycle, next state FETCH at target_i.
- REQ-025 Any pc with pc[1:0]!=0 entering FETCH SHALL instead enter EXC with no bus request: ready_o=1, exc_addr_o=1, inst_o=32'h0000_0033, pc_o=misaligned pc.
- REQ-026 EXC with stall_i=0: next state PARK; PARK: ready_o=0, ireq_o=0 until jump_i.
- REQ-027 When ready_o=0, inst_o SHALL be 32'h0000_0033 and exc_addr_o=0.
- REQ-028 pc+4 and pc_add4_o SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.

Reset
- REQ-029 rst=0 SHALL immediately force: state FETCH, pc=RESET_ADDR, ireq_o=0, ready_o=0, exc_addr_o=0, inst_o=32'h0000_0033, pc_o=RESET_ADDR, pc_add4_o=RESET_ADDR+4.
- REQ-030 ireq_o SHALL rise no earlier than the first clock edge after rst deasserts.
- REQ-031 Reset mid-transaction SHALL abandon the outstanding request; an iack_i arriving after reset without a new request SHALL be ignored.

Verification
- REQ-032 Reset release, iack_i 2 cycles after ireq_o, idata_i=32'h00500093 -> ready_o=1, pc_o=0, pc_add4_o=4, inst_o=32'h00500093; next request iaddr_o=4.
- REQ-033 stall_i=1 for 3 cycles in VALID -> ready_o, pc_o, inst_o unchanged for all 3 cycles; no ireq_o; advance to pc=8 after release.
- REQ-034 jump_i target 32'h100 while request to 32'h8 pending, ack 2 cycles later -> that data never presented; next iaddr_o=32'h100.
- REQ-035 jump_i target 32'h102 -> no ireq_o, ready_o=1, exc_addr_o=1, pc_o=32'h102, inst_o=32'h33; then PARK until jump_i to 32'h200 resumes fetch.
- REQ-036 rst asserted during pending request -> outputs at reset values same cycle; fetch restarts at RESET_ADDR.
- REQ-037 pc=32'hFFFF_FFFC fetch -> pc_add4_o=0, next iaddr_o=0.
